add_issue_queue: RTL

Operand queue and result/status stage wrapped around the combinational 32-bit adder (`add`). Accepts add requests over a valid/ready handshake, buffers them in a small FIFO, presents the head entry to the adder, and captures the adder's sum and flags into an output register with its own valid/ready handshake. Also holds the architectural NZCV status register, updated only by requests marked set-flags.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/add_req_fifo.sv | 59 +++++
 rtl/add_issue_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared width, flag bit positions and request record for the add issue path.
`default_nettype none

package alu_pkg;

   localparam int W = 32;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sign;
      logic         setflags;
   } add_req_t;

endpackage

`default_nettype wire

// File: rtl/add_req_fifo.sv
// Request FIFO of add_req_t with flush; count distinguishes full from empty.
`default_nettype none

module add_req_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  alu_pkg::add_req_t          push_data,
   output alu_pkg::add_req_t          head,
   output logic [$clog2(DEPTH):0]     count
);
   import alu_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   add_req_t        r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/add_issue_queue.sv
// Operand queue feeding an external combinational adder, with a result
// register handshake and the architectural NZCV status register.
`default_nettype none

module add_issue_queue #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_a,
   input  logic [W-1:0]           in_b,
   input  logic                   in_sign,
   input  logic                   in_setflags,
   output logic [W-1:0]           add_a,
   output logic [W-1:0]           add_b,
   output logic                   add_sign,
   input  logic [W-1:0]           add_res,
   input  logic                   add_n,
   input  logic                   add_z,
   input  logic                   add_c,
   input  logic                   add_v,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_res,
   output logic [3:0]             out_flags,
   output logic [3:0]             status_nzcv,
   output logic [$clog2(DEPTH):0] count
);
   import alu_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   add_req_t        w_push_data;
   add_req_t        w_head;
   logic            w_head_valid;
   logic            w_push;
   logic            w_pop;
   logic [3:0]      w_flags;

   logic            r_out_valid;
   logic [W-1:0]    r_out_res;
   logic [3:0]      r_out_flags;
   logic [3:0]      r_status;

   assign w_push_data = '{a: in_a, b: in_b, sign: in_sign, setflags: in_setflags};

   // Full blocks a push even when a pop frees a slot on the same edge.
   assign in_ready     = (count < CW'(DEPTH)) && !flush;
   assign w_push       = in_valid && in_ready;
   assign w_head_valid = (count != '0);
   assign w_pop        = w_head_valid && (!r_out_valid || out_ready) && !flush;

   assign add_a    = w_head_valid ? w_head.a    : '0;
   assign add_b    = w_head_valid ? w_head.b    : '0;
   assign add_sign = w_head_valid ? w_head.sign : 1'b0;

   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_N] = add_n;
      w_flags[FLAG_Z] = add_z;
      w_flags[FLAG_C] = add_c;
      w_flags[FLAG_V] = add_v;
   end

   add_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (w_push),
      .pop       (w_pop),
      .push_data (w_push_data),
      .head      (w_head),
      .count     (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_res   <= '0;
         r_out_flags <= '0;
         r_status    <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_pop) begin
         r_out_valid <= 1'b1;
         r_out_res   <= add_res;
         r_out_flags <= w_flags;
         if (w_head.setflags) begin
            r_status <= w_flags;
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_res     = r_out_res;
   assign out_flags   = r_out_flags;
   assign status_nzcv = r_status;

endmodule

`default_nettype wire
